// File: rtl/img_stream_gen_pkg.sv
// Shared types and constants for the RGB888 test-pattern stream source.
package img_stream_pkg;

  // Frame sequencer states: idle, pre-line gap, active pixels, post-frame tail, inter-frame gap.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HGAP   = 3'd1,
    ACTIVE = 3'd2,
    VTAIL  = 3'd3,
    FGAP   = 3'd4
  } state_e;

  // Pattern selectors.
  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_RAMP  = 2'd1;
  localparam logic [1:0] PAT_CHECK = 2'd2;
  localparam logic [1:0] PAT_MOVE  = 2'd3;

  // Colour-bar palette, left to right.
  localparam logic [23:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

endpackage

// File: rtl/img_stream_gen_pattern_rom.sv
// Combinational pixel generator: maps pattern mode and pixel coordinates to RGB888.
module img_pattern_rom
  import img_stream_pkg::*;
(
  input  logic [1:0]  pat_mode,
  input  logic [11:0] col,
  input  logic [11:0] row,
  input  logic [7:0]  fidx,
  input  logic [2:0]  bar_idx,
  output logic [23:0] rgb
);

  logic [7:0] ramp_b;
  logic [7:0] move_r;
  logic [7:0] move_g;

  // Select the pixel value for the requested pattern; sums wrap at 8 bits.
  always_comb begin
    ramp_b = col[7:0] + row[7:0];
    move_r = col[7:0] + fidx;
    move_g = row[7:0] + fidx;
    rgb    = 24'h000000;
    case (pat_mode)
      PAT_BARS:  rgb = BAR_RGB[bar_idx];
      PAT_RAMP:  rgb = {col[7:0], row[7:0], ramp_b};
      PAT_CHECK: rgb = (col[3] ^ row[3]) ? 24'hFFFFFF : 24'h000000;
      PAT_MOVE:  rgb = {move_r, move_g, fidx};
      default:   rgb = 24'h000000;
    endcase
  end

endmodule

// File: rtl/img_stream_gen.sv
// Test-pattern video source driving the scaler per_img_* input with fixed frame/line timing.
// Control handshake: start is a one-cycle request honoured only while the sequencer is idle;
// busy rises the cycle after acceptance and stays high until the sequencer is idle again,
// so a new start is meaningful once busy has been observed low.
module img_stream_gen
  import img_stream_pkg::*;
#(
  parameter int C_SRC_IMG_WIDTH  = 640,
  parameter int C_SRC_IMG_HEIGHT = 480,
  parameter int C_HGAP           = 3,
  parameter int C_VTAIL          = 5,
  parameter int C_FGAP           = 1
) (
  input  logic        clk_in1,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic [1:0]  pat_mode,
  input  logic [7:0]  frame_num,
  output logic        busy,
  output logic        frame_done,
  output logic        per_img_vsync,
  output logic        per_img_href,
  output logic [7:0]  per_img_red,
  output logic [7:0]  per_img_green,
  output logic [7:0]  per_img_blue,
  output state_e      dbg_state
);

  localparam int          BAR_W      = (C_SRC_IMG_WIDTH / 8 < 1) ? 1 : C_SRC_IMG_WIDTH / 8;
  localparam logic [11:0] COL_LAST   = 12'(C_SRC_IMG_WIDTH - 1);
  localparam logic [11:0] ROW_LAST   = 12'(C_SRC_IMG_HEIGHT - 1);
  localparam logic [11:0] BAR_LAST   = 12'(BAR_W - 1);
  localparam logic [7:0]  HGAP_LAST  = 8'(C_HGAP - 1);
  localparam logic [7:0]  VTAIL_LAST = 8'(C_VTAIL - 1);
  localparam logic [7:0]  FGAP_LAST  = 8'(C_FGAP - 1);

  state_e      state, state_n;
  logic [11:0] col, col_n;
  logic [11:0] row, row_n;
  logic [7:0]  gap, gap_n;
  logic [7:0]  fidx, fidx_n;
  logic [7:0]  frame_lat, frame_lat_n;
  logic        stop_lat, stop_lat_n;
  logic [1:0]  pat_lat, pat_lat_n;
  logic [2:0]  bar_idx, bar_idx_n;
  logic [11:0] bar_cnt, bar_cnt_n;
  logic [23:0] pix_rgb;

  assign dbg_state = state;

  img_pattern_rom u_rom (
    .pat_mode (pat_lat),
    .col      (col),
    .row      (row),
    .fidx     (fidx),
    .bar_idx  (bar_idx),
    .rgb      (pix_rgb)
  );

  // Sequencer and counter registers.
  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      col       <= '0;
      row       <= '0;
      gap       <= '0;
      fidx      <= '0;
      frame_lat <= '0;
      stop_lat  <= 1'b0;
      pat_lat   <= '0;
      bar_idx   <= '0;
      bar_cnt   <= '0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      gap       <= gap_n;
      fidx      <= fidx_n;
      frame_lat <= frame_lat_n;
      stop_lat  <= stop_lat_n;
      pat_lat   <= pat_lat_n;
      bar_idx   <= bar_idx_n;
      bar_cnt   <= bar_cnt_n;
    end
  end

  // Next-state and counter update; fidx counts completed frames and doubles as the frame index.
  always_comb begin
    state_n     = state;
    col_n       = col;
    row_n       = row;
    gap_n       = gap;
    fidx_n      = fidx;
    frame_lat_n = frame_lat;
    stop_lat_n  = stop_lat | stop;
    pat_lat_n   = pat_lat;
    bar_idx_n   = bar_idx;
    bar_cnt_n   = bar_cnt;
    case (state)
      IDLE: begin
        stop_lat_n = 1'b0;
        if (start) begin
          state_n     = HGAP;
          frame_lat_n = frame_num;
          fidx_n      = '0;
          stop_lat_n  = stop;
          gap_n       = '0;
          row_n       = '0;
          pat_lat_n   = pat_mode;
        end
      end
      HGAP: begin
        if (gap == HGAP_LAST) begin
          state_n   = ACTIVE;
          col_n     = '0;
          bar_idx_n = '0;
          bar_cnt_n = '0;
        end else begin
          gap_n = gap + 8'd1;
        end
      end
      ACTIVE: begin
        if (col == COL_LAST) begin
          gap_n = '0;
          if (row == ROW_LAST) begin
            state_n = VTAIL;
          end else begin
            state_n = HGAP;
            row_n   = row + 12'd1;
          end
        end else begin
          col_n = col + 12'd1;
          // The last bar never advances, so it absorbs any width remainder.
          if (bar_cnt == BAR_LAST && bar_idx != 3'd7) begin
            bar_idx_n = bar_idx + 3'd1;
            bar_cnt_n = '0;
          end else begin
            bar_cnt_n = bar_cnt + 12'd1;
          end
        end
      end
      VTAIL: begin
        if (gap == VTAIL_LAST) begin
          state_n = FGAP;
          gap_n   = '0;
          fidx_n  = fidx + 8'd1;
        end else begin
          gap_n = gap + 8'd1;
        end
      end
      FGAP: begin
        if (gap == FGAP_LAST) begin
          if ((stop_lat | stop) || (frame_lat != 8'd0 && fidx == frame_lat)) begin
            state_n = IDLE;
          end else begin
            state_n   = HGAP;
            gap_n     = '0;
            row_n     = '0;
            pat_lat_n = pat_mode;
          end
        end else begin
          gap_n = gap + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Registered stream outputs decoded from the current sequencer position.
  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      per_img_vsync <= 1'b0;
      per_img_href  <= 1'b0;
      per_img_red   <= '0;
      per_img_green <= '0;
      per_img_blue  <= '0;
    end else begin
      busy          <= (state != IDLE);
      frame_done    <= (state == FGAP) && (gap == 8'd0);
      per_img_vsync <= (state == HGAP) || (state == ACTIVE) || (state == VTAIL);
      per_img_href  <= (state == ACTIVE);
      if (state == ACTIVE) begin
        {per_img_red, per_img_green, per_img_blue} <= pix_rgb;
      end else begin
        {per_img_red, per_img_green, per_img_blue} <= 24'h000000;
      end
    end
  end

endmodule
